elevator_request_scheduler: RTL and testbench

Collects per-floor call-button presses into a pending-request register and dispatches them one at a time to `elevator_fsm` as `floor_request`/`request_valid` pulses. It uses SCAN ordering: keep travelling in the current direction while requests remain ahead, then reverse. It sits between the button inputs and `elevator_fsm`, and infers car state from the FSM's `current_floor`, `moving` and `door_open` outputs.

---
 rtl/elevator_request_scheduler_pkg.sv | 18 +
 rtl/elevator_request_scheduler_if.sv | 29 ++
 rtl/elevator_request_scheduler_scan_target_select.sv | 64 ++++++
 rtl/elevator_request_scheduler.sv | 121 ++++++++++++
 tb/tb_elevator_request_scheduler.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_request_scheduler_pkg.sv
// Shared definitions for the elevator request scheduler: default sizing,
// scheduler state encoding and scan-direction constants.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_START  = 2'd2,
    WAIT_ARRIVE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Signal bundle between the call buttons / elevator_fsm side (master) and the
// request scheduler (slave).
interface elevator_request_scheduler_if #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
);

  logic [NUM_FLOORS-1:0] call_btn;
  logic                  cancel_all;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  car_moving;
  logic                  car_door_open;
  logic [FLOOR_W-1:0]    floor_request;
  logic                  request_valid;
  logic [NUM_FLOORS-1:0] pending;
  logic                  direction;
  logic                  busy;

  modport master (
    output call_btn, cancel_all, current_floor, car_moving, car_door_open,
    input  floor_request, request_valid, pending, direction, busy
  );

  modport slave (
    input  call_btn, cancel_all, current_floor, car_moving, car_door_open,
    output floor_request, request_valid, pending, direction, busy
  );

endinterface

// File: rtl/elevator_request_scheduler_scan_target_select.sv
// SCAN target picker: serve the current floor first, then the nearest request
// ahead in the travel direction, otherwise reverse toward the nearest one behind.
module scan_target_select #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    current_floor_i,
  input  logic                  direction_i,
  output logic [FLOOR_W-1:0]    target_o,
  output logic                  new_dir_o,
  output logic                  found_o
);
  import elevator_pkg::*;

  int                 curIdx;
  logic               hereHit;
  logic               upHit;
  logic               downHit;
  logic [FLOOR_W-1:0] upFloor;
  logic [FLOOR_W-1:0] downFloor;

  // Descending scan leaves the closest floor above; ascending the closest below.
  always_comb begin
    curIdx    = int'(current_floor_i);
    hereHit   = 1'b0;
    upHit     = 1'b0;
    downHit   = 1'b0;
    upFloor   = '0;
    downFloor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_i[i] && (i > curIdx)) begin
        upHit   = 1'b1;
        upFloor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_i[i] && (i < curIdx)) begin
        downHit   = 1'b1;
        downFloor = FLOOR_W'(i);
      end
      if (pending_i[i] && (i == curIdx)) begin
        hereHit = 1'b1;
      end
    end
  end

  always_comb begin
    target_o  = current_floor_i;
    new_dir_o = direction_i;
    found_o   = 1'b1;
    if (hereHit) begin
      target_o = current_floor_i;
    end else if (direction_i == DIR_UP ? upHit : downHit) begin
      target_o = (direction_i == DIR_UP) ? upFloor : downFloor;
    end else if (direction_i == DIR_UP ? downHit : upHit) begin
      target_o  = (direction_i == DIR_UP) ? downFloor : upFloor;
      new_dir_o = ~direction_i;
    end else begin
      found_o = 1'b0;
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Collects floor calls and dispatches them one at a time to elevator_fsm in
// SCAN order, watching the car to detect start, arrival or a stalled request.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS    = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W       = elevator_pkg::FLOOR_W,
  parameter int START_TIMEOUT = 8
) (
  input logic                          clk,
  input logic                          reset,
  elevator_request_scheduler_if.slave  bus
);
  import elevator_pkg::*;

  localparam int TIMER_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);

  sched_state_e          state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  direction_q, direction_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic [FLOOR_W-1:0]    floor_request_q, floor_request_d;
  logic                  request_valid_q, request_valid_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;

  logic                  carIdle;
  logic                  dispatch;
  logic                  arriveHit;
  logic [NUM_FLOORS-1:0] clrMask;
  logic [FLOOR_W-1:0]    selTarget;
  logic                  selDir;
  logic                  selFound;

  assign carIdle = !bus.car_moving && !bus.car_door_open;

  scan_target_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_select (
    .pending_i       (pending_q),
    .current_floor_i (bus.current_floor),
    .direction_i     (direction_q),
    .target_o        (selTarget),
    .new_dir_o       (selDir),
    .found_o         (selFound)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.cancel_all) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:        if (pending_q != '0 && carIdle && selFound) state_d = ISSUE;
        ISSUE:       state_d = WAIT_START;
        WAIT_START:  if (!carIdle) state_d = WAIT_ARRIVE;
                     else if (timer_q == TIMER_LAST) state_d = IDLE;
        WAIT_ARRIVE: if (carIdle) state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  // A new press on the floor being cleared survives because call_btn is OR-ed in last.
  always_comb begin
    dispatch  = !bus.cancel_all && (state_q == IDLE) && (pending_q != '0) && carIdle && selFound;
    arriveHit = (state_q == WAIT_ARRIVE) && carIdle && (bus.current_floor == target_q);
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clrMask[i] = arriveHit && (target_q == FLOOR_W'(i));
    end
    pending_d       = bus.cancel_all ? '0 : ((pending_q & ~clrMask) | bus.call_btn);
    direction_d     = direction_q;
    target_d        = target_q;
    floor_request_d = floor_request_q;
    request_valid_d = 1'b0;
    timer_d         = timer_q;
    if (dispatch) begin
      direction_d     = selDir;
      target_d        = selTarget;
      floor_request_d = selTarget;
      request_valid_d = 1'b1;
    end
    if (state_q == ISSUE) begin
      timer_d = '0;
    end else if (state_q == WAIT_START && carIdle && timer_q != TIMER_LAST) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q       <= '0;
      direction_q     <= DIR_UP;
      target_q        <= '0;
      floor_request_q <= '0;
      request_valid_q <= 1'b0;
      timer_q         <= '0;
    end else begin
      pending_q       <= pending_d;
      direction_q     <= direction_d;
      target_q        <= target_d;
      floor_request_q <= floor_request_d;
      request_valid_q <= request_valid_d;
      timer_q         <= timer_d;
    end
  end

  assign bus.floor_request = floor_request_q;
  assign bus.request_valid = request_valid_q;
  assign bus.pending       = pending_q;
  assign bus.direction     = direction_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler: walks the car through
// dispatch, SCAN reversal, set-vs-clear, timeout retry, cancel and reset cases.
module tb_elevator_request_scheduler;

  logic clk;
  logic reset;
  int   totalChecks;
  int   badChecks;
  int   rvCount;
  int   rvBase;
  logic prevRv;

  elevator_request_scheduler_if #(.NUM_FLOORS(4), .FLOOR_W(2)) schedIf ();

  elevator_request_scheduler #(
    .NUM_FLOORS    (4),
    .FLOOR_W       (2),
    .START_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (schedIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] btn, input logic cancel, input logic [1:0] floor,
                               input logic moving, input logic door);
    schedIf.call_btn      = btn;
    schedIf.cancel_all    = cancel;
    schedIf.current_floor = floor;
    schedIf.car_moving    = moving;
    schedIf.car_door_open = door;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe counter plus a back-to-back guard, sampled mid-cycle.
  initial prevRv = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (schedIf.request_valid === 1'b1) rvCount++;
      checkOutput("rvBackToBack", {31'b0, schedIf.request_valid & prevRv}, 32'd0);
      prevRv = schedIf.request_valid;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rvCount     = 0;
    reset       = 1'b1;
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step(2);
    reset = 1'b0;
    checkOutput("rstPending", {28'b0, schedIf.pending}, 32'd0);
    checkOutput("rstBusy", {31'b0, schedIf.busy}, 32'd0);
    checkOutput("rstDir", {31'b0, schedIf.direction}, 32'd1);
    checkOutput("rstValid", {31'b0, schedIf.request_valid}, 32'd0);
    checkOutput("rstFloorReq", {30'b0, schedIf.floor_request}, 32'd0);

    $display("[TB] single call to floor 2");
    rvBase = rvCount;
    applyStimulus(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("s1PendingSet", {28'b0, schedIf.pending}, 32'h4);
    checkOutput("s1NoEarlyValid", {31'b0, schedIf.request_valid}, 32'd0);
    step(1);
    checkOutput("s1Valid", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s1Floor", {30'b0, schedIf.floor_request}, 32'd2);
    checkOutput("s1Dir", {31'b0, schedIf.direction}, 32'd1);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1);
    checkOutput("s1ValidDrop", {31'b0, schedIf.request_valid}, 32'd0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
    step(1);
    checkOutput("s1PendingClr", {28'b0, schedIf.pending}, 32'd0);
    checkOutput("s1Idle", {31'b0, schedIf.busy}, 32'd0);
    checkOutput("s1PulseCount", rvCount - rvBase, 32'd1);

    $display("[TB] scan up then reverse from floor 2");
    applyStimulus(4'b1010, 1'b0, 2'd2, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("s2Pending", {28'b0, schedIf.pending}, 32'hA);
    step(1);
    checkOutput("s2FirstValid", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s2FirstFloor", {30'b0, schedIf.floor_request}, 32'd3);
    checkOutput("s2FirstDir", {31'b0, schedIf.direction}, 32'd1);
    applyStimulus(4'b0000, 1'b0, 2'd2, 1'b1, 1'b0);
    step(2);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1);
    checkOutput("s2PendingAfter", {28'b0, schedIf.pending}, 32'h2);
    step(1);
    checkOutput("s2SecondValid", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s2SecondFloor", {30'b0, schedIf.floor_request}, 32'd1);
    checkOutput("s2SecondDir", {31'b0, schedIf.direction}, 32'd0);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    step(2);
    applyStimulus(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1);
    checkOutput("s2Done", {28'b0, schedIf.pending}, 32'd0);

    $display("[TB] press on target floor during the clear cycle");
    applyStimulus(4'b1000, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1);
    checkOutput("s3Valid", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s3Floor", {30'b0, schedIf.floor_request}, 32'd3);
    checkOutput("s3Dir", {31'b0, schedIf.direction}, 32'd1);
    applyStimulus(4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
    step(2);
    applyStimulus(4'b1000, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    checkOutput("s3SetWins", {28'b0, schedIf.pending}, 32'h8);
    checkOutput("s3BackIdle", {31'b0, schedIf.busy}, 32'd0);
    step(1);
    checkOutput("s3Reissue", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s3ReissueFloor", {30'b0, schedIf.floor_request}, 32'd3);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0, 1'b1);
    step(2);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1);
    checkOutput("s3Cleared", {28'b0, schedIf.pending}, 32'd0);

    $display("[TB] start timeout and retry");
    applyStimulus(4'b0001, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1);
    checkOutput("s4Valid", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s4Floor", {30'b0, schedIf.floor_request}, 32'd0);
    checkOutput("s4Dir", {31'b0, schedIf.direction}, 32'd0);
    step(8);
    checkOutput("s4StillWaiting", {31'b0, schedIf.busy}, 32'd1);
    step(1);
    checkOutput("s4TimedOut", {31'b0, schedIf.busy}, 32'd0);
    checkOutput("s4PendingKept", {28'b0, schedIf.pending}, 32'h1);
    step(1);
    checkOutput("s4Retry", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s4RetryFloor", {30'b0, schedIf.floor_request}, 32'd0);

    $display("[TB] cancel during arrival wait");
    applyStimulus(4'b1010, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1);
    checkOutput("s5Pending", {28'b0, schedIf.pending}, 32'hB);
    checkOutput("s5Busy", {31'b0, schedIf.busy}, 32'd1);
    rvBase = rvCount;
    applyStimulus(4'b0000, 1'b1, 2'd3, 1'b1, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    checkOutput("s5Flushed", {28'b0, schedIf.pending}, 32'd0);
    checkOutput("s5NotBusy", {31'b0, schedIf.busy}, 32'd0);
    step(4);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    step(3);
    checkOutput("s5NoValid", rvCount - rvBase, 32'd0);

    $display("[TB] car stops short of target");
    applyStimulus(4'b0001, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    step(1);
    checkOutput("s6Floor", {30'b0, schedIf.floor_request}, 32'd0);
    applyStimulus(4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    step(2);
    applyStimulus(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1);
    checkOutput("s6Kept", {28'b0, schedIf.pending}, 32'h1);
    checkOutput("s6Idle", {31'b0, schedIf.busy}, 32'd0);
    step(1);
    checkOutput("s6Reissue", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s6ReissueFloor", {30'b0, schedIf.floor_request}, 32'd0);
    checkOutput("s6ReissueDir", {31'b0, schedIf.direction}, 32'd0);
    applyStimulus(4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
    step(2);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1);
    checkOutput("s6Cleared", {28'b0, schedIf.pending}, 32'd0);

    $display("[TB] current-floor call then async reset mid-dispatch");
    applyStimulus(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1);
    checkOutput("s7HereValid", {31'b0, schedIf.request_valid}, 32'd1);
    checkOutput("s7HereDir", {31'b0, schedIf.direction}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s7RstValid", {31'b0, schedIf.request_valid}, 32'd0);
    checkOutput("s7RstBusy", {31'b0, schedIf.busy}, 32'd0);
    checkOutput("s7RstPending", {28'b0, schedIf.pending}, 32'd0);
    checkOutput("s7RstDir", {31'b0, schedIf.direction}, 32'd1);
    step(1);
    reset = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
